// File: rtl/expgolomb_packer.sv
// Exp-Golomb codeword former and MSB-first 32-bit word packer.
// Each accepted code number n with m = floor(log2(n+1)) becomes m zeros
// followed by n+1 in m+1 bits; codewords are concatenated into a left-aligned
// bit accumulator and drained as full words, or as a zero-padded tail on flush.
module expgolomb_packer #(
    parameter int unsigned VAL_W  = 19,
    parameter int unsigned LOG_W  = 5,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VAL_W-1:0]  in_val,
    input  logic [LOG_W-1:0]  in_log2,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [5:0]        out_bits,
    output logic              out_last,
    output logic              flush_done,
    output logic              err
);

    localparam int unsigned ACC_W  = WORD_W + 2 * VAL_W + 1;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);
    localparam int unsigned CODE_W = VAL_W + 1;

    // Architectural state
    logic [ACC_W-1:0]  r_acc;
    logic [FILL_W-1:0] r_fill;
    logic              r_flush_pending;
    logic              r_err;

    // Registered output view
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic [5:0]        r_out_bits;
    logic              r_out_last;
    logic              r_flush_done;

    // Codeword formation
    logic [LOG_W-1:0]  w_m;
    logic [LOG_W-1:0]  w_mask_sh;
    logic [CODE_W-1:0] w_np1;
    logic [CODE_W-1:0] w_mask;
    logic [CODE_W-1:0] w_code;
    logic [FILL_W-1:0] w_len;
    logic [FILL_W-1:0] w_shift;
    logic [ACC_W-1:0]  w_placed;
    logic              w_bad;

    // Handshakes
    logic              w_accept;
    logic              w_full;
    logic              w_out_fire;

    // Next state
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_fp_nxt;
    logic              w_err_nxt;
    logic              w_done_nxt;

    // Next output view
    logic              w_ov_nxt;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_data_nxt;
    logic [5:0]        w_bits_nxt;
    logic              w_last_nxt;

    // Input side is open only while a whole word is not yet buffered and no flush runs
    assign in_ready   = (r_fill < FILL_W'(WORD_W)) && !r_flush_pending;
    assign w_accept   = in_valid && in_ready;
    assign w_full     = (r_fill >= FILL_W'(WORD_W));
    assign w_out_fire = r_out_valid && out_ready;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_bits   = r_out_bits;
    assign out_last   = r_out_last;
    assign flush_done = r_flush_done;
    assign err        = r_err;

    // Build the codeword and position it at the current fill point.
    // An out-of-range prefix length is saturated so the accumulator can never overflow.
    always_comb begin
        w_m       = (in_log2 > LOG_W'(VAL_W)) ? LOG_W'(VAL_W) : in_log2;
        w_np1     = CODE_W'(in_val) + CODE_W'(1);
        w_mask_sh = LOG_W'(VAL_W) - w_m;
        w_mask    = {CODE_W{1'b1}} >> w_mask_sh;
        w_code    = w_np1 & w_mask;
        w_bad     = ((w_np1 >> in_log2) != CODE_W'(1));
        w_len     = FILL_W'({w_m, 1'b1});
        w_shift   = FILL_W'(ACC_W) - r_fill - w_len;
        w_placed  = ACC_W'(w_code) << w_shift;
    end

    // Next-state: append on accept, drain on output handshake, retire flush
    always_comb begin
        w_acc_nxt  = r_acc;
        w_fill_nxt = r_fill;
        w_fp_nxt   = r_flush_pending;
        w_err_nxt  = r_err;
        w_done_nxt = 1'b0;

        if (w_accept) begin
            w_acc_nxt  = r_acc | w_placed;
            w_fill_nxt = r_fill + w_len;
            if (w_bad) begin
                w_err_nxt = 1'b1;
            end
        end

        if (w_out_fire) begin
            if (w_full) begin
                w_acc_nxt  = r_acc << WORD_W;
                w_fill_nxt = r_fill - FILL_W'(WORD_W);
            end else begin
                w_acc_nxt  = '0;
                w_fill_nxt = '0;
                w_fp_nxt   = 1'b0;
                w_done_nxt = 1'b1;
            end
        end else if (r_flush_pending && (r_fill == '0)) begin
            // Flush found nothing left once full words were gone: finish without a tail
            w_fp_nxt   = 1'b0;
            w_done_nxt = 1'b1;
        end

        // A request while a flush is already running is ignored
        if (in_flush && !r_flush_pending) begin
            w_fp_nxt = 1'b1;
        end
    end

    // Output view derived from the next state so it lines up with the state registers
    always_comb begin
        w_ov_nxt = (w_fill_nxt >= FILL_W'(WORD_W)) || (w_fp_nxt && (w_fill_nxt != '0));
        w_word   = w_acc_nxt[ACC_W-1 -: WORD_W];
        if (w_fill_nxt < FILL_W'(WORD_W)) begin
            w_word = w_word & ~({WORD_W{1'b1}} >> w_fill_nxt);
        end
        w_data_nxt = '0;
        w_bits_nxt = '0;
        w_last_nxt = 1'b0;
        if (w_ov_nxt) begin
            w_data_nxt = w_word;
            if (w_fill_nxt >= FILL_W'(WORD_W)) begin
                w_bits_nxt = 6'(WORD_W);
            end else begin
                w_bits_nxt = 6'(w_fill_nxt);
                w_last_nxt = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc           <= '0;
            r_fill          <= '0;
            r_flush_pending <= 1'b0;
            r_err           <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_bits      <= '0;
            r_out_last      <= 1'b0;
            r_flush_done    <= 1'b0;
        end else begin
            r_acc           <= w_acc_nxt;
            r_fill          <= w_fill_nxt;
            r_flush_pending <= w_fp_nxt;
            r_err           <= w_err_nxt;
            r_out_valid     <= w_ov_nxt;
            r_out_data      <= w_data_nxt;
            r_out_bits      <= w_bits_nxt;
            r_out_last      <= w_last_nxt;
            r_flush_done    <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_expgolomb_packer.sv
// Bench for expgolomb_packer: bit-queue reference model of the codeword stream,
// directed scenarios followed by randomized traffic with random back-pressure.
module tb_expgolomb_packer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_val;
    logic [4:0]  in_log2;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_last;
    logic        flush_done;
    logic        err;

    expgolomb_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_val     (in_val),
        .in_log2    (in_log2),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bits   (out_bits),
        .out_last   (out_last),
        .flush_done (flush_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: pending bitstream plus flush / done / error flags
    bit          q[$];
    logic        m_fp;
    logic        m_done;
    logic        m_err;

    // Words actually taken by the sink: {data, bits, last}
    logic [38:0] obs[$];
    int          done_seen;

    int unsigned rm;
    int unsigned rn;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return at posedge+1
    task automatic step();
        int          sz;
        logic        er;
        logic        ev;
        logic        fp_old;
        logic        fire_in;
        logic        fire_out;
        logic [31:0] ew;
        logic [5:0]  eb;
        logic        el;
        int unsigned np1;
        int unsigned mm;
        @(negedge clk);
        sz = q.size();
        er = (sz < 32) && !m_fp;
        ev = (sz >= 32) || (m_fp && sz > 0);
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("flush_done", 64'(flush_done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
        if (flush_done === 1'b1) done_seen++;
        if (ev) begin
            ew = '0;
            for (int i = 0; i < 32 && i < sz; i++) ew[31-i] = q[i];
            eb = (sz >= 32) ? 6'd32 : 6'(sz);
            el = (sz < 32);
            chk("out_data", 64'(out_data), 64'(ew));
            chk("out_bits", 64'(out_bits), 64'(eb));
            chk("out_last", 64'(out_last), 64'(el));
        end
        fp_old   = m_fp;
        fire_in  = in_valid && er;
        fire_out = ev && out_ready;
        m_done   = 1'b0;
        if (fire_out) begin
            obs.push_back({out_data, out_bits, out_last});
            if (sz >= 32) begin
                repeat (32) void'(q.pop_front());
            end else begin
                q.delete();
                m_fp   = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_fp && sz == 0) begin
            m_fp   = 1'b0;
            m_done = 1'b1;
        end
        if (fire_in) begin
            mm  = 32'(in_log2);
            np1 = 32'(in_val) + 1;
            for (int i = 0; i < int'(mm); i++) q.push_back(1'b0);
            for (int i = int'(mm); i >= 0; i--) q.push_back(bit'((np1 >> i) & 1));
            if ((np1 >> mm) != 1) m_err = 1'b1;
        end
        if (in_flush && !fp_old) m_fp = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        checks = 0; errors = 0; done_seen = 0;
        m_fp = 1'b0; m_done = 1'b0; m_err = 1'b0;
        clk = 1'b0; reset_n = 1'b0;
        in_valid = 1'b0; in_val = '0; in_log2 = '0; in_flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_bits", 64'(out_bits), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 32 single-bit codewords then flush: one full word, no tail
        obs.delete(); done_seen = 0;
        in_valid = 1'b1; in_val = 19'd0; in_log2 = 5'd0;
        repeat (32) step();
        in_valid = 1'b0; in_flush = 1'b1;
        step();
        drain(5);
        chk("t1_words", 64'(obs.size()), 64'd1);
        if (obs.size() >= 1) chk("t1_word0", 64'(obs[0]), 64'({32'hFFFF_FFFF, 6'd32, 1'b0}));
        chk("t1_done_cnt", 64'(done_seen), 64'd1);

        // n=3 with simultaneous flush: 5-bit tail
        obs.delete(); done_seen = 0;
        in_valid = 1'b1; in_val = 19'd3; in_log2 = 5'd2; in_flush = 1'b1;
        step();
        drain(5);
        chk("t2_words", 64'(obs.size()), 64'd1);
        if (obs.size() >= 1) chk("t2_word0", 64'(obs[0]), 64'({32'h2000_0000, 6'd5, 1'b1}));
        chk("t2_done_cnt", 64'(done_seen), 64'd1);

        // Longest codeword: full word plus 7-bit zero tail
        obs.delete();
        in_valid = 1'b1; in_val = 19'h7FFFF; in_log2 = 5'd19; in_flush = 1'b1;
        step();
        drain(6);
        chk("t3_words", 64'(obs.size()), 64'd2);
        if (obs.size() >= 2) begin
            chk("t3_word0", 64'(obs[0]), 64'({32'h0000_1000, 6'd32, 1'b0}));
            chk("t3_word1", 64'(obs[1]), 64'({32'h0000_0000, 6'd7, 1'b1}));
        end

        // Back-pressure with a full word waiting and input still offered
        obs.delete();
        in_valid = 1'b1; in_val = 19'h7FFFF; in_log2 = 5'd19; out_ready = 1'b0;
        step();
        repeat (10) step();
        chk("t4_in_ready_held", 64'(in_ready), 64'd0);
        chk("t4_data_held", 64'(out_data), 64'h0000_1000);
        out_ready = 1'b1;
        repeat (3) step();
        in_valid = 1'b0; in_flush = 1'b1;
        step();
        drain(8);
        chk("t4_words", 64'(obs.size()), 64'd3);

        // Inconsistent log2: sticky error, code built from in_log2 as given
        obs.delete();
        in_valid = 1'b1; in_val = 19'd5; in_log2 = 5'd1; in_flush = 1'b1;
        step();
        drain(4);
        chk("t5_err", 64'(err), 64'd1);
        if (obs.size() >= 1) chk("t5_word0", 64'(obs[0]), 64'({32'h4000_0000, 6'd3, 1'b1}));
        in_valid = 1'b1; in_val = 19'd6; in_log2 = 5'd2;
        step();
        drain(3);
        chk("t5_err_sticky", 64'(err), 64'd1);

        // Reset while a tail word is pending
        in_valid = 1'b1; in_val = 19'd3; in_log2 = 5'd2; in_flush = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; in_flush = 1'b0;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        chk("t6_out_bits", 64'(out_bits), 64'd0);
        chk("t6_out_last", 64'(out_last), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        q.delete(); m_fp = 1'b0; m_done = 1'b0; m_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        obs.delete();
        drain(5);
        chk("t6_no_word", 64'(obs.size()), 64'd0);

        // Randomized traffic, back-pressure, flushes and occasional bad log2
        for (int k = 0; k < 800; k++) begin
            rm = $urandom_range(0, 19);
            rn = (32'd1 << rm) - 1 + ($urandom % (32'd1 << rm));
            if (rm == 19) rn = 32'h7FFFF;
            if ($urandom_range(0, 99) < 3) rm = $urandom_range(0, 19);
            in_val    = 19'(rn);
            in_log2   = 5'(rm);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            in_flush  = ($urandom_range(0, 99) < 4);
            step();
        end
        in_valid = 1'b0; in_flush = 1'b1;
        step();
        drain(12);
        chk("rand_empty_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
